reorder_buffer: RTL and testbench
=================================

# reorder_buffer

Two-wide in-order retirement buffer directly downstream of the register renamer. It accepts up to two renamed instructions per cycle in program order, records completion reported by execution units, and retires up to two completed instructions per cycle from the head. On retire it returns the previous physical mapping (`old_preg`) to the renamer's free pool and presents the committed architectural/physical pair.

## Interface
Parameters:
- `NUM_A_REGS`, 32, architectural register count; `A_W = $clog2(NUM_A_REGS)`
- `NUM_P_REGS`, 64, physical register count; `P_W = $clog2(NUM_P_REGS)`
- `NUM_ENTRIES`, 16, ROB depth, power of two, ≥4; `IDX_W = $clog2(NUM_ENTRIES)`

Ports:
- `clk_i` in 1: clock; all state updates on posedge
- `rst_i` in 1: synchronous, active-high reset
- `dispatch_en0_i`, `dispatch_en1_i` in 1: allocate an entry for instruction slot 0 / slot 1
- `dispatch_has_dest0_i`, `dispatch_has_dest1_i` in 1: instruction writes a register
- `dispatch_areg0_i`, `dispatch_areg1_i` in A_W: architectural destination
- `dispatch_preg0_i`, `dispatch_preg1_i` in P_W: new physical destination (renamer `p_dest`)
- `dispatch_old_preg0_i`, `dispatch_old_preg1_i` in P_W: previous mapping (renamer `old_dest`)
- `alloc_idx0_o`, `alloc_idx1_o` out IDX_W: combinational ROB index assigned to slot 0 / slot 1 this cycle
- `complete_en0_i`, `complete_en1_i` in 1: execution result written back
- `complete_idx0_i`, `complete_idx1_i` in IDX_W: ROB index completing
- `retire_en0_o`, `retire_en1_o` out 1: registered, entry retired at last edge
- `retire_areg0_o`, `retire_areg1_o` out A_W; `retire_preg0_o`, `retire_preg1_o` out P_W: committed mapping
- `en_free_reg0_o`, `en_free_reg1_o` out 1; `free_reg0_o`, `free_reg1_o` out P_W: to renamer free inputs
- `rob_full_o` out 1: combinational, `count > NUM_ENTRIES-2`; dispatch must stall
- `rob_empty_o` out 1: combinational, `count == 0`
- `count_o` out IDX_W+1: occupied entries

## Operation
- Circular buffer; `head` (oldest), `tail` (next free), `count`; pointers wrap modulo NUM_ENTRIES.
- Entry fields: `valid`, `done`, `has_dest`, `areg`, `preg`, `old_preg`.
- Index assignment: `alloc_idx0_o = tail`; `alloc_idx1_o = tail + dispatch_en0_i` (wrapped). Slot 1 alone takes `tail`.
- Dispatch at edge: each enabled slot writes its entry with `valid=1, done=0`; `tail += en0+en1`.
- Dispatch while `rob_full_o` was high: dropped entirely, no state change, `$display` error.
- Completion at edge: if entry at index is valid, set `done=1`; invalid index ignored. Both ports may hit distinct entries same edge.
- Retire at edge, using pre-edge state: slot 0 retires if `head` valid and done; slot 1 retires `head+1` only if slot 0 retires and `head+1` valid and done. Retired entries cleared; `head += r0+r1`.
- Retire outputs registered: `retire_en*` = retired, `retire_areg/preg` = entry fields, `en_free_reg*_o = retired && has_dest && old_preg != 0`, `free_reg*_o = old_preg`. All retire outputs zero when not retiring.
- `count` next = `count + dispatched − retired`; dispatch and retire in the same edge are legal.

## Timing
- Reset: head=tail=count=0, all valid/done cleared, all registered outputs 0; `rob_empty_o=1`, `rob_full_o=0`. Reset mid-operation discards all entries; reset overrides dispatch/complete that edge.
- Completion at edge N → earliest retire at edge N+1 → `retire_en`/`en_free_reg` high during cycle after N+1, for exactly one cycle → renamer frees at edge N+2.
- Dispatch at edge N → entry visible for completion at edge N+1; completion in same edge as dispatch of that index is ignored.
- Entry completed in the same edge it would retire is not retired that edge.
- Full boundary: with count = NUM_ENTRIES−1, `rob_full_o=1`; a single free slot is never used.
- Wrap-around: tail and head cross from NUM_ENTRIES−1 to 0 without gap; two-wide dispatch/retire may straddle the wrap.

## Test plan
- Reset, dispatch 2 (areg 5/6, preg 33/34, old 5/6), complete both at next edge → one edge later `retire_en0/1=1`, `free_reg0/1=5/6`, `en_free=1`, count returns 0.
- Out-of-order completion: dispatch idx 0,1,2; complete 2 then 1 → no retire; complete 0 → 0 and 1 retire together, 2 retires next edge.
- Fill to 15 entries (NUM_ENTRIES=16) → `rob_full_o=1`; further dispatch dropped, count stays 15; retire one → full clears.
- Wrap: cycle 40 instructions through two-wide → indices wrap 15→0, retire order matches dispatch order, no lost/duplicate frees.
- `has_dest=0` and `old_preg=0` entries retire with `retire_en=1`, `en_free_reg=0`.
- Assert `rst_i` with 6 entries pending, 3 done → next cycle count 0, empty 1, no retire outputs.

Source files
------------

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//
// Two-wide in-order retirement buffer that sits directly after the register
// renamer. Up to two renamed instructions are allocated per cycle in program
// order. Execution units report completion by ROB index. Up to two completed
// instructions retire per cycle from the head. On retire the previous physical
// mapping is handed back to the renamer's free pool, and the committed
// architectural/physical pair is presented.
//
// Ports
//   clk_i, rst_i                      clock, synchronous active-high reset
//   dispatch_en{0,1}_i                allocate an entry for slot 0 / slot 1
//   dispatch_has_dest{0,1}_i          instruction writes a register
//   dispatch_areg{0,1}_i              architectural destination
//   dispatch_preg{0,1}_i              new physical destination
//   dispatch_old_preg{0,1}_i          previous physical mapping
//   alloc_idx{0,1}_o                  combinational index given to each slot
//   complete_en{0,1}_i                execution result written back
//   complete_idx{0,1}_i               ROB index that completed
//   retire_en{0,1}_o                  registered, entry retired at last edge
//   retire_areg{0,1}_o                committed architectural register
//   retire_preg{0,1}_o                committed physical register
//   en_free_reg{0,1}_o                return free_reg to the free pool
//   free_reg{0,1}_o                   physical register being released
//   rob_full_o                        count > NUM_ENTRIES-2, dispatch must stall
//   rob_empty_o                       count == 0
//   count_o                           number of occupied entries
// -----------------------------------------------------------------------------
module reorder_buffer #(
    parameter int NUM_A_REGS  = 32,
    parameter int NUM_P_REGS  = 64,
    parameter int NUM_ENTRIES = 16,
    localparam int A_W   = $clog2(NUM_A_REGS),
    localparam int P_W   = $clog2(NUM_P_REGS),
    localparam int IDX_W = $clog2(NUM_ENTRIES)
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             dispatch_en0_i,
    input  logic             dispatch_en1_i,
    input  logic             dispatch_has_dest0_i,
    input  logic             dispatch_has_dest1_i,
    input  logic [A_W-1:0]   dispatch_areg0_i,
    input  logic [A_W-1:0]   dispatch_areg1_i,
    input  logic [P_W-1:0]   dispatch_preg0_i,
    input  logic [P_W-1:0]   dispatch_preg1_i,
    input  logic [P_W-1:0]   dispatch_old_preg0_i,
    input  logic [P_W-1:0]   dispatch_old_preg1_i,
    output logic [IDX_W-1:0] alloc_idx0_o,
    output logic [IDX_W-1:0] alloc_idx1_o,

    input  logic             complete_en0_i,
    input  logic             complete_en1_i,
    input  logic [IDX_W-1:0] complete_idx0_i,
    input  logic [IDX_W-1:0] complete_idx1_i,

    output logic             retire_en0_o,
    output logic             retire_en1_o,
    output logic [A_W-1:0]   retire_areg0_o,
    output logic [A_W-1:0]   retire_areg1_o,
    output logic [P_W-1:0]   retire_preg0_o,
    output logic [P_W-1:0]   retire_preg1_o,
    output logic             en_free_reg0_o,
    output logic             en_free_reg1_o,
    output logic [P_W-1:0]   free_reg0_o,
    output logic [P_W-1:0]   free_reg1_o,

    output logic             rob_full_o,
    output logic             rob_empty_o,
    output logic [IDX_W:0]   count_o
);

    localparam int CNT_W = IDX_W + 1;

    // Per-entry data that only matters while the entry is valid.
    typedef struct packed {
        logic           has_dest;
        logic [A_W-1:0] areg;
        logic [P_W-1:0] preg;
        logic [P_W-1:0] old_preg;
    } payload_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0]       head_q;
    logic [IDX_W-1:0]       tail_q;
    logic [CNT_W-1:0]       count_q;
    logic [NUM_ENTRIES-1:0] valid_q;
    logic [NUM_ENTRIES-1:0] done_q;
    payload_t               payload_q [NUM_ENTRIES];

    // -------------------------------------------------------------------------
    // Status and allocation
    // -------------------------------------------------------------------------
    assign rob_full_o   = count_q > CNT_W'(NUM_ENTRIES - 2);
    assign rob_empty_o  = count_q == '0;
    assign count_o      = count_q;

    // Slot 1 takes the slot after slot 0 only when slot 0 is also allocating;
    // index arithmetic wraps naturally because NUM_ENTRIES is a power of two.
    assign alloc_idx0_o = tail_q;
    assign alloc_idx1_o = tail_q + IDX_W'(dispatch_en0_i);

    // A dispatch presented while full is dropped as a whole, both slots.
    logic do_disp0;
    logic do_disp1;
    assign do_disp0 = dispatch_en0_i && !rob_full_o;
    assign do_disp1 = dispatch_en1_i && !rob_full_o;

    // -------------------------------------------------------------------------
    // Retire selection from pre-edge state
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] head1;
    logic             retire0;
    logic             retire1;

    assign head1   = head_q + IDX_W'(1);
    assign retire0 = valid_q[head_q] && done_q[head_q];
    // Slot 1 can never overtake slot 0; retirement stays strictly in order.
    assign retire1 = retire0 && valid_q[head1] && done_q[head1];

    logic [CNT_W-1:0] n_disp;
    logic [CNT_W-1:0] n_ret;
    assign n_disp = CNT_W'(do_disp0) + CNT_W'(do_disp1);
    assign n_ret  = CNT_W'(retire0) + CNT_W'(retire1);

    // -------------------------------------------------------------------------
    // Next-state of the valid/done vectors
    // -------------------------------------------------------------------------
    logic [NUM_ENTRIES-1:0] valid_d;
    logic [NUM_ENTRIES-1:0] done_d;

    // NOTE: every variable is given its default first so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;

        // Completion only lands on entries that were already valid before the
        // edge, so completing an index in the same edge it is dispatched is
        // ignored. Entries are not done before the edge they complete, hence
        // they cannot also retire in that same edge.
        if (complete_en0_i && valid_q[complete_idx0_i]) begin
            done_d[complete_idx0_i] = 1'b1;
        end
        if (complete_en1_i && valid_q[complete_idx1_i]) begin
            done_d[complete_idx1_i] = 1'b1;
        end

        if (retire0) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
        end
        if (retire1) begin
            valid_d[head1] = 1'b0;
            done_d[head1]  = 1'b0;
        end

        // Allocation targets free entries, so it never collides with the
        // clears above; it is applied last so a fresh entry always starts
        // not-done.
        if (do_disp0) begin
            valid_d[alloc_idx0_o] = 1'b1;
            done_d[alloc_idx0_o]  = 1'b0;
        end
        if (do_disp1) begin
            valid_d[alloc_idx1_o] = 1'b1;
            done_d[alloc_idx1_o]  = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Control state and registered retire outputs
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            valid_q        <= '0;
            done_q         <= '0;
            retire_en0_o   <= 1'b0;
            retire_en1_o   <= 1'b0;
            retire_areg0_o <= '0;
            retire_areg1_o <= '0;
            retire_preg0_o <= '0;
            retire_preg1_o <= '0;
            en_free_reg0_o <= 1'b0;
            en_free_reg1_o <= 1'b0;
            free_reg0_o    <= '0;
            free_reg1_o    <= '0;
        end else begin
            head_q  <= head_q + IDX_W'(n_ret);
            tail_q  <= tail_q + IDX_W'(n_disp);
            count_q <= count_q + n_disp - n_ret;
            valid_q <= valid_d;
            done_q  <= done_d;

            retire_en0_o   <= retire0;
            retire_en1_o   <= retire1;
            retire_areg0_o <= retire0 ? payload_q[head_q].areg     : '0;
            retire_areg1_o <= retire1 ? payload_q[head1].areg      : '0;
            retire_preg0_o <= retire0 ? payload_q[head_q].preg     : '0;
            retire_preg1_o <= retire1 ? payload_q[head1].preg      : '0;
            free_reg0_o    <= retire0 ? payload_q[head_q].old_preg : '0;
            free_reg1_o    <= retire1 ? payload_q[head1].old_preg  : '0;
            // Physical register 0 is never returned to the free pool.
            en_free_reg0_o <= retire0 && payload_q[head_q].has_dest
                              && (payload_q[head_q].old_preg != '0);
            en_free_reg1_o <= retire1 && payload_q[head1].has_dest
                              && (payload_q[head1].old_preg != '0);
        end
    end

    // -------------------------------------------------------------------------
    // Entry payload storage
    // -------------------------------------------------------------------------
    // NOTE: the payload array has no reset; it is only ever read behind a
    // valid bit, and leaving it unreset lets it map onto plain storage.
    always_ff @(posedge clk_i) begin
        if (do_disp0) begin
            payload_q[alloc_idx0_o] <= '{has_dest: dispatch_has_dest0_i,
                                         areg:     dispatch_areg0_i,
                                         preg:     dispatch_preg0_i,
                                         old_preg: dispatch_old_preg0_i};
        end
        if (do_disp1) begin
            payload_q[alloc_idx1_o] <= '{has_dest: dispatch_has_dest1_i,
                                         areg:     dispatch_areg1_i,
                                         preg:     dispatch_preg1_i,
                                         old_preg: dispatch_old_preg1_i};
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

    localparam int N     = 16;
    localparam int A_W   = 5;
    localparam int P_W   = 6;
    localparam int IDX_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic             dispatch_en0_i = 1'b0, dispatch_en1_i = 1'b0;
    logic             dispatch_has_dest0_i = 1'b0, dispatch_has_dest1_i = 1'b0;
    logic [A_W-1:0]   dispatch_areg0_i = '0, dispatch_areg1_i = '0;
    logic [P_W-1:0]   dispatch_preg0_i = '0, dispatch_preg1_i = '0;
    logic [P_W-1:0]   dispatch_old_preg0_i = '0, dispatch_old_preg1_i = '0;
    logic [IDX_W-1:0] alloc_idx0_o, alloc_idx1_o;
    logic             complete_en0_i = 1'b0, complete_en1_i = 1'b0;
    logic [IDX_W-1:0] complete_idx0_i = '0, complete_idx1_i = '0;
    logic             retire_en0_o, retire_en1_o;
    logic [A_W-1:0]   retire_areg0_o, retire_areg1_o;
    logic [P_W-1:0]   retire_preg0_o, retire_preg1_o;
    logic             en_free_reg0_o, en_free_reg1_o;
    logic [P_W-1:0]   free_reg0_o, free_reg1_o;
    logic             rob_full_o, rob_empty_o;
    logic [IDX_W:0]   count_o;

    reorder_buffer #(.NUM_A_REGS(32), .NUM_P_REGS(64), .NUM_ENTRIES(N)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .dispatch_en0_i(dispatch_en0_i), .dispatch_en1_i(dispatch_en1_i),
        .dispatch_has_dest0_i(dispatch_has_dest0_i),
        .dispatch_has_dest1_i(dispatch_has_dest1_i),
        .dispatch_areg0_i(dispatch_areg0_i), .dispatch_areg1_i(dispatch_areg1_i),
        .dispatch_preg0_i(dispatch_preg0_i), .dispatch_preg1_i(dispatch_preg1_i),
        .dispatch_old_preg0_i(dispatch_old_preg0_i),
        .dispatch_old_preg1_i(dispatch_old_preg1_i),
        .alloc_idx0_o(alloc_idx0_o), .alloc_idx1_o(alloc_idx1_o),
        .complete_en0_i(complete_en0_i), .complete_en1_i(complete_en1_i),
        .complete_idx0_i(complete_idx0_i), .complete_idx1_i(complete_idx1_i),
        .retire_en0_o(retire_en0_o), .retire_en1_o(retire_en1_o),
        .retire_areg0_o(retire_areg0_o), .retire_areg1_o(retire_areg1_o),
        .retire_preg0_o(retire_preg0_o), .retire_preg1_o(retire_preg1_o),
        .en_free_reg0_o(en_free_reg0_o), .en_free_reg1_o(en_free_reg1_o),
        .free_reg0_o(free_reg0_o), .free_reg1_o(free_reg1_o),
        .rob_full_o(rob_full_o), .rob_empty_o(rob_empty_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: the ROB is simply a program-ordered queue of in-flight
    // instructions; each remembers the index it was handed at allocation.
    typedef struct {
        int idx;
        bit hd;
        int areg;
        int preg;
        int oldp;
        bit done;
    } ent_t;

    ent_t q[$];
    int   tail_m = 0;

    task automatic clear_inputs();
        dispatch_en0_i = 0; dispatch_en1_i = 0;
        complete_en0_i = 0; complete_en1_i = 0;
    endtask

    task automatic disp(input int slot, input bit hd, input int areg,
                        input int preg, input int oldp);
        if (slot == 0) begin
            dispatch_en0_i = 1; dispatch_has_dest0_i = hd;
            dispatch_areg0_i = A_W'(areg); dispatch_preg0_i = P_W'(preg);
            dispatch_old_preg0_i = P_W'(oldp);
        end else begin
            dispatch_en1_i = 1; dispatch_has_dest1_i = hd;
            dispatch_areg1_i = A_W'(areg); dispatch_preg1_i = P_W'(preg);
            dispatch_old_preg1_i = P_W'(oldp);
        end
    endtask

    task automatic cmpl(input int port, input int idx);
        if (port == 0) begin complete_en0_i = 1; complete_idx0_i = IDX_W'(idx); end
        else           begin complete_en1_i = 1; complete_idx1_i = IDX_W'(idx); end
    endtask

    // One clock edge: check combinational outputs, advance the model, clock
    // the DUT, check registered outputs, then clear the input strobes.
    task automatic step(input bit rst);
        int cnt;
        bit full, r0, r1;
        int e_a0, e_a1, e_p0, e_p1, e_f0, e_f1;
        bit e_ef0, e_ef1;
        #1;
        cnt  = q.size();
        full = cnt > N - 2;
        check("count", count_o, cnt);
        check("empty", rob_empty_o, cnt == 0);
        check("full", rob_full_o, full);
        check("alloc0", alloc_idx0_o, tail_m);
        check("alloc1", alloc_idx1_o, (tail_m + int'(dispatch_en0_i)) % N);

        r0 = 0; r1 = 0;
        e_a0 = 0; e_a1 = 0; e_p0 = 0; e_p1 = 0; e_f0 = 0; e_f1 = 0;
        e_ef0 = 0; e_ef1 = 0;
        if (rst) begin
            q.delete();
            tail_m = 0;
        end else begin
            r0 = cnt > 0 && q[0].done;
            r1 = r0 && cnt > 1 && q[1].done;
            if (r0) begin
                e_a0 = q[0].areg; e_p0 = q[0].preg; e_f0 = q[0].oldp;
                e_ef0 = q[0].hd && q[0].oldp != 0;
            end
            if (r1) begin
                e_a1 = q[1].areg; e_p1 = q[1].preg; e_f1 = q[1].oldp;
                e_ef1 = q[1].hd && q[1].oldp != 0;
            end
            foreach (q[i]) begin
                if (complete_en0_i && q[i].idx == int'(complete_idx0_i)) q[i].done = 1;
                if (complete_en1_i && q[i].idx == int'(complete_idx1_i)) q[i].done = 1;
            end
            if (r0) void'(q.pop_front());
            if (r1) void'(q.pop_front());
            if (!full) begin
                if (dispatch_en0_i) begin
                    q.push_back('{tail_m, dispatch_has_dest0_i, int'(dispatch_areg0_i),
                                  int'(dispatch_preg0_i), int'(dispatch_old_preg0_i), 0});
                    tail_m = (tail_m + 1) % N;
                end
                if (dispatch_en1_i) begin
                    q.push_back('{tail_m, dispatch_has_dest1_i, int'(dispatch_areg1_i),
                                  int'(dispatch_preg1_i), int'(dispatch_old_preg1_i), 0});
                    tail_m = (tail_m + 1) % N;
                end
            end
        end

        rst_i = rst;
        @(posedge clk_i);
        #1;
        rst_i = 0;
        check("retire_en0", retire_en0_o, r0);
        check("retire_en1", retire_en1_o, r1);
        check("retire_areg0", retire_areg0_o, e_a0);
        check("retire_areg1", retire_areg1_o, e_a1);
        check("retire_preg0", retire_preg0_o, e_p0);
        check("retire_preg1", retire_preg1_o, e_p1);
        check("free_reg0", free_reg0_o, e_f0);
        check("free_reg1", free_reg1_o, e_f1);
        check("en_free0", en_free_reg0_o, e_ef0);
        check("en_free1", en_free_reg1_o, e_ef1);
        clear_inputs();
    endtask

    initial begin
        // Basic two-wide round trip.
        step(1);
        disp(0, 1, 5, 33, 5); disp(1, 1, 6, 34, 6); step(0);
        cmpl(0, 0); cmpl(1, 1); step(0);
        step(0);
        check("t1_free0", free_reg0_o, 5);
        check("t1_free1", free_reg1_o, 6);
        check("t1_enfree", {en_free_reg1_o, en_free_reg0_o}, 3);
        check("t1_count", count_o, 0);

        // Out-of-order completion retires in order.
        step(1);
        disp(0, 1, 1, 40, 11); disp(1, 1, 2, 41, 12); step(0);
        disp(0, 1, 3, 42, 13); step(0);
        cmpl(0, 2); step(0);
        cmpl(1, 1); step(0);
        check("t2_no_retire", retire_en0_o, 0);
        cmpl(0, 0); step(0);
        step(0);
        check("t2_pair", {retire_en1_o, retire_en0_o}, 3);
        step(0);
        check("t2_last", retire_preg0_o, 42);

        // Fill boundary: full at 15, further dispatch dropped.
        step(1);
        for (int i = 0; i < 7; i++) begin
            disp(0, 1, i, 10 + i, 20 + i); disp(1, 1, i + 1, 30 + i, 40 + i); step(0);
        end
        disp(0, 1, 9, 9, 9); step(0);
        check("t3_full", rob_full_o, 1);
        disp(0, 1, 1, 1, 1); disp(1, 1, 2, 2, 2); step(0);
        check("t3_count15", count_o, 15);
        cmpl(0, 0); step(0);
        step(0);
        check("t3_full_clear", rob_full_o, 0);

        // No-destination and old_preg==0 entries retire without a free.
        step(1);
        disp(0, 0, 4, 50, 7); disp(1, 1, 8, 51, 0); step(0);
        cmpl(0, 0); cmpl(1, 1); step(0);
        step(0);
        check("t4_retired", {retire_en1_o, retire_en0_o}, 3);
        check("t4_nofree", {en_free_reg1_o, en_free_reg0_o}, 0);

        // Reset discards pending work, including done entries.
        step(1);
        for (int i = 0; i < 3; i++) begin
            disp(0, 1, i, 20 + i, 1 + i); disp(1, 1, i + 3, 30 + i, 4 + i); step(0);
        end
        cmpl(0, 2); cmpl(1, 3); step(0);
        cmpl(0, 4); step(0);
        cmpl(0, 0); disp(0, 1, 7, 7, 7); step(1);
        check("t5_count", count_o, 0);
        check("t5_empty", rob_empty_o, 1);

        // Randomised traffic: wraps many times, mixes full-stall attempts,
        // random and stale completion indices.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) != 0)
                disp(0, 1'($urandom_range(0, 4) != 0), $urandom_range(0, 31),
                     $urandom_range(0, 63), $urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 63));
            if ($urandom_range(0, 2) != 0)
                disp(1, 1'($urandom_range(0, 4) != 0), $urandom_range(0, 31),
                     $urandom_range(0, 63), $urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 63));
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 2) != 0) begin
                    if (q.size() > 0 && $urandom_range(0, 7) != 0)
                        cmpl(p, q[$urandom_range(0, q.size() - 1)].idx);
                    else
                        cmpl(p, $urandom_range(0, N - 1));
                end
            end
            step(c == 250);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
